// File: rtl/hctrl_mc_if.sv
// Hazard-control bundle: pipeline-stage status toward the hazard unit and
// stall/flush/forward controls back to the pipeline.
interface hctrl_mc_if #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
);
    logic [REG_AW-1:0] ID_Rs, ID_Rt, EX_Rs, EX_Rt;
    logic [REG_AW-1:0] EX_WA, MEM_WA, WB_WA;
    logic              EX_MemtoReg, MEM_MemtoReg;
    logic              EX_RegWrite, MEM_RegWrite, WB_RegWrite;
    logic              ID_Branch, ID_MD_use, EX_MD_start, branch_taken;
    logic              npc_stall, IF_stall, ID_clr, IF_flush;
    logic [1:0]        FowardAE, FowardBE, FowardAD, FowardBD;
    logic              md_busy;
    logic [CNT_W-1:0]  stall_cnt;

    // The pipeline drives stage status and consumes the controls.
    modport master (
        output ID_Rs, ID_Rt, EX_Rs, EX_Rt, EX_WA, MEM_WA, WB_WA,
               EX_MemtoReg, MEM_MemtoReg, EX_RegWrite, MEM_RegWrite, WB_RegWrite,
               ID_Branch, ID_MD_use, EX_MD_start, branch_taken,
        input  npc_stall, IF_stall, ID_clr, IF_flush,
               FowardAE, FowardBE, FowardAD, FowardBD, md_busy, stall_cnt
    );

    // The hazard unit reads stage status and produces the controls.
    modport slave (
        input  ID_Rs, ID_Rt, EX_Rs, EX_Rt, EX_WA, MEM_WA, WB_WA,
               EX_MemtoReg, MEM_MemtoReg, EX_RegWrite, MEM_RegWrite, WB_RegWrite,
               ID_Branch, ID_MD_use, EX_MD_start, branch_taken,
        output npc_stall, IF_stall, ID_clr, IF_flush,
               FowardAE, FowardBE, FowardAD, FowardBD, md_busy, stall_cnt
    );
endinterface

// File: rtl/hctrl_mc.sv
// Pipeline hazard controller: operand forwarding selects, load-use / branch /
// mul-div stall generation, branch flush, mul-div occupancy tracking and a
// saturating stalled-cycle counter.
// The controls are combinational (stage status plus md_busy only); md_busy
// and stall_cnt are registered. md_dbg_o exposes {busy_state, md_cnt}.
module hctrl_mc #(
    parameter int REG_AW    = 5,
    parameter int MD_LAT    = 4,
    parameter int BR_EX_FWD = 1,
    parameter int CNT_W     = 32
) (
    input  logic        clk,
    input  logic        reset,
    hctrl_mc_if.slave   hz,
    output logic [4:0]  md_dbg_o
);
    typedef enum logic { MD_IDLE = 1'b0, MD_BUSY = 1'b1 } md_state_t;

    localparam logic [3:0] MD_LOAD = 4'(MD_LAT - 1);
    localparam logic       EX_FWD  = (BR_EX_FWD != 0);

    md_state_t        state_q;
    logic [3:0]       md_cnt_q;
    logic             md_busy_q;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic             load_stall, br_stall, md_stall, stall;

    // A producer matches a source only when it writes a nonzero register.
    function automatic logic hit(input logic [REG_AW-1:0] src,
                                 input logic [REG_AW-1:0] wa,
                                 input logic              wr);
        return wr && (wa != '0) && (src == wa);
    endfunction

    function automatic logic [1:0] fwd_ex(input logic [REG_AW-1:0] src);
        if (hit(src, hz.MEM_WA, hz.MEM_RegWrite))     return 2'b10;
        else if (hit(src, hz.WB_WA, hz.WB_RegWrite))  return 2'b01;
        else                                          return 2'b00;
    endfunction

    // Without the EX->ID path an EX match falls through to MEM/WB.
    function automatic logic [1:0] fwd_id(input logic [REG_AW-1:0] src);
        if (EX_FWD && hit(src, hz.EX_WA, hz.EX_RegWrite)) return 2'b11;
        else if (hit(src, hz.MEM_WA, hz.MEM_RegWrite))    return 2'b10;
        else if (hit(src, hz.WB_WA, hz.WB_RegWrite))      return 2'b01;
        else                                              return 2'b00;
    endfunction

    // Forwarding selects and stall/flush decisions.
    always_comb begin
        load_stall = hit(hz.ID_Rs, hz.EX_WA,  hz.EX_MemtoReg)  |
                     hit(hz.ID_Rt, hz.EX_WA,  hz.EX_MemtoReg)  |
                     hit(hz.ID_Rs, hz.MEM_WA, hz.MEM_MemtoReg) |
                     hit(hz.ID_Rt, hz.MEM_WA, hz.MEM_MemtoReg);
        br_stall   = !EX_FWD && hz.ID_Branch &&
                     (hit(hz.ID_Rs, hz.EX_WA, hz.EX_RegWrite) |
                      hit(hz.ID_Rt, hz.EX_WA, hz.EX_RegWrite));
        md_stall   = hz.ID_MD_use && md_busy_q;
        stall      = load_stall | br_stall | md_stall;
    end

    assign hz.npc_stall = stall;
    assign hz.IF_stall  = stall;
    assign hz.ID_clr    = stall;
    assign hz.IF_flush  = hz.branch_taken & ~stall;
    assign hz.FowardAE  = fwd_ex(hz.EX_Rs);
    assign hz.FowardBE  = fwd_ex(hz.EX_Rt);
    assign hz.FowardAD  = fwd_id(hz.ID_Rs);
    assign hz.FowardBD  = fwd_id(hz.ID_Rt);
    assign hz.md_busy   = md_busy_q;
    assign hz.stall_cnt = stall_cnt_q;
    assign md_dbg_o     = {state_q == MD_BUSY, md_cnt_q};

    // Mul/div occupancy FSM; a new issue while busy is ignored.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= MD_IDLE;
            md_cnt_q  <= 4'd0;
            md_busy_q <= 1'b0;
        end else begin
            case (state_q)
                MD_IDLE: begin
                    if (hz.EX_MD_start) begin
                        state_q   <= MD_BUSY;
                        md_cnt_q  <= MD_LOAD;
                        md_busy_q <= 1'b1;
                    end
                end
                MD_BUSY: begin
                    if (md_cnt_q != 4'd0) begin
                        md_cnt_q <= md_cnt_q - 4'd1;
                    end else begin
                        state_q   <= MD_IDLE;
                        md_busy_q <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= MD_IDLE;
                    md_busy_q <= 1'b0;
                end
            endcase
        end
    end

    // Stalled-cycle count holds at all-ones instead of wrapping.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end

    // Stall counter register.
    always_ff @(posedge clk) begin
        if (reset) stall_cnt_q <= '0;
        else       stall_cnt_q <= stall_cnt_d;
    end
endmodule

// File: tb/tb_hctrl_mc.sv
// Bench for hctrl_mc: two instances (EX->ID forwarding on with 32-bit counter,
// off with 4-bit counter) share one stimulus stream. Each cycle the driver
// advances a cycle-level reference model, pushes expected outputs, and a
// monitor on the falling edge pops and compares.
module tb_hctrl_mc;
    localparam int MD_LAT = 4;
    localparam int WA = 45;
    localparam int WB = 17;

    typedef struct packed {
        logic [4:0] id_rs, id_rt, ex_rs, ex_rt, ex_wa, mem_wa, wb_wa;
        logic ex_m2r, mem_m2r, ex_rw, mem_rw, wb_rw;
        logic id_branch, id_md_use, ex_md_start, branch_taken, rst;
    } stim_t;

    logic clk = 1'b0;
    stim_t cur, prev;
    logic [4:0] dbg_a, dbg_b;

    hctrl_mc_if #(.REG_AW(5), .CNT_W(32)) a_if ();
    hctrl_mc_if #(.REG_AW(5), .CNT_W(4))  b_if ();

    hctrl_mc #(.REG_AW(5), .MD_LAT(MD_LAT), .BR_EX_FWD(1), .CNT_W(32)) dut_a (
        .clk(clk), .reset(cur.rst), .hz(a_if.slave), .md_dbg_o(dbg_a));
    hctrl_mc #(.REG_AW(5), .MD_LAT(MD_LAT), .BR_EX_FWD(0), .CNT_W(4)) dut_b (
        .clk(clk), .reset(cur.rst), .hz(b_if.slave), .md_dbg_o(dbg_b));

    // Both instances see identical stage status.
    assign a_if.ID_Rs = cur.id_rs;          assign b_if.ID_Rs = cur.id_rs;
    assign a_if.ID_Rt = cur.id_rt;          assign b_if.ID_Rt = cur.id_rt;
    assign a_if.EX_Rs = cur.ex_rs;          assign b_if.EX_Rs = cur.ex_rs;
    assign a_if.EX_Rt = cur.ex_rt;          assign b_if.EX_Rt = cur.ex_rt;
    assign a_if.EX_WA = cur.ex_wa;          assign b_if.EX_WA = cur.ex_wa;
    assign a_if.MEM_WA = cur.mem_wa;        assign b_if.MEM_WA = cur.mem_wa;
    assign a_if.WB_WA = cur.wb_wa;          assign b_if.WB_WA = cur.wb_wa;
    assign a_if.EX_MemtoReg = cur.ex_m2r;   assign b_if.EX_MemtoReg = cur.ex_m2r;
    assign a_if.MEM_MemtoReg = cur.mem_m2r; assign b_if.MEM_MemtoReg = cur.mem_m2r;
    assign a_if.EX_RegWrite = cur.ex_rw;    assign b_if.EX_RegWrite = cur.ex_rw;
    assign a_if.MEM_RegWrite = cur.mem_rw;  assign b_if.MEM_RegWrite = cur.mem_rw;
    assign a_if.WB_RegWrite = cur.wb_rw;    assign b_if.WB_RegWrite = cur.wb_rw;
    assign a_if.ID_Branch = cur.id_branch;  assign b_if.ID_Branch = cur.id_branch;
    assign a_if.ID_MD_use = cur.id_md_use;  assign b_if.ID_MD_use = cur.id_md_use;
    assign a_if.EX_MD_start = cur.ex_md_start; assign b_if.EX_MD_start = cur.ex_md_start;
    assign a_if.branch_taken = cur.branch_taken; assign b_if.branch_taken = cur.branch_taken;

    // Clock.
    always #5 clk = ~clk;

    // Scoreboard state and reference model state.
    logic [WA-1:0] exp_a_q[$];
    logic [WB-1:0] exp_b_q[$];
    int n_cmp = 0;
    int n_bad = 0;
    int md_rem = 0;            // mul/div cycles still to run
    logic [31:0] sa = '0;
    logic [3:0]  sb = '0;
    logic prev_st_a = 1'b0, prev_st_b = 1'b0;

    function automatic logic match(input logic [4:0] src, input logic [4:0] wa, input logic wr);
        return wr && (wa != 5'd0) && (src == wa);
    endfunction

    function automatic logic [1:0] m_fwd_e(input logic [4:0] src, input stim_t s);
        if (match(src, s.mem_wa, s.mem_rw)) return 2'b10;
        if (match(src, s.wb_wa, s.wb_rw))   return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic [1:0] m_fwd_d(input logic [4:0] src, input stim_t s, input logic ex_ok);
        if (ex_ok && match(src, s.ex_wa, s.ex_rw)) return 2'b11;
        if (match(src, s.mem_wa, s.mem_rw))        return 2'b10;
        if (match(src, s.wb_wa, s.wb_rw))          return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic m_stall(input stim_t s, input logic ex_ok, input logic busy);
        logic ld, br;
        ld = match(s.id_rs, s.ex_wa, s.ex_m2r) || match(s.id_rt, s.ex_wa, s.ex_m2r) ||
             match(s.id_rs, s.mem_wa, s.mem_m2r) || match(s.id_rt, s.mem_wa, s.mem_m2r);
        br = !ex_ok && s.id_branch &&
             (match(s.id_rs, s.ex_wa, s.ex_rw) || match(s.id_rt, s.ex_wa, s.ex_rw));
        return ld || br || (s.id_md_use && busy);
    endfunction

    // Driver: advance the model across the edge, apply new inputs, push expectations.
    task automatic step(input stim_t s);
        logic busy, st_a, st_b;
        @(posedge clk);
        #1;
        if (prev.rst) begin
            md_rem = 0; sa = '0; sb = '0;
        end else begin
            if (prev_st_a && sa != 32'hFFFF_FFFF) sa = sa + 1;
            if (prev_st_b && sb != 4'hF) sb = sb + 1;
            if (md_rem > 0) md_rem = md_rem - 1;
            else if (prev.ex_md_start) md_rem = MD_LAT;
        end
        cur  = s;
        busy = (md_rem > 0);
        st_a = m_stall(s, 1'b1, busy);
        st_b = m_stall(s, 1'b0, busy);
        exp_a_q.push_back({st_a, st_a, st_a, s.branch_taken & ~st_a,
                           m_fwd_e(s.ex_rs, s), m_fwd_e(s.ex_rt, s),
                           m_fwd_d(s.id_rs, s, 1'b1), m_fwd_d(s.id_rt, s, 1'b1), busy, sa});
        exp_b_q.push_back({st_b, st_b, st_b, s.branch_taken & ~st_b,
                           m_fwd_e(s.ex_rs, s), m_fwd_e(s.ex_rt, s),
                           m_fwd_d(s.id_rs, s, 1'b0), m_fwd_d(s.id_rt, s, 1'b0), busy, sb});
        prev = s; prev_st_a = st_a; prev_st_b = st_b;
    endtask

    function automatic stim_t rnd();
        stim_t s;
        s.id_rs = 5'($urandom_range(0, 7));  s.id_rt = 5'($urandom_range(0, 7));
        s.ex_rs = 5'($urandom_range(0, 7));  s.ex_rt = 5'($urandom_range(0, 7));
        s.ex_wa = 5'($urandom_range(0, 7));  s.mem_wa = 5'($urandom_range(0, 7));
        s.wb_wa = 5'($urandom_range(0, 7));
        s.ex_m2r = ($urandom_range(0, 3) == 0); s.mem_m2r = ($urandom_range(0, 3) == 0);
        s.ex_rw = 1'($urandom_range(0, 1)); s.mem_rw = 1'($urandom_range(0, 1));
        s.wb_rw = 1'($urandom_range(0, 1)); s.id_branch = 1'($urandom_range(0, 1));
        s.id_md_use = 1'($urandom_range(0, 1));
        s.ex_md_start = ($urandom_range(0, 5) == 0);
        s.branch_taken = 1'($urandom_range(0, 1));
        s.rst = ($urandom_range(0, 99) == 0);
        return s;
    endfunction

    // Monitor: every cycle presents a full output set; compare against the head.
    always @(negedge clk) begin
        logic [WA-1:0] ea, ga;
        logic [WB-1:0] eb, gb;
        if (exp_a_q.size() > 0 && exp_b_q.size() > 0) begin
            ea = exp_a_q.pop_front();
            eb = exp_b_q.pop_front();
            ga = {a_if.npc_stall, a_if.IF_stall, a_if.ID_clr, a_if.IF_flush,
                  a_if.FowardAE, a_if.FowardBE, a_if.FowardAD, a_if.FowardBD,
                  a_if.md_busy, a_if.stall_cnt};
            gb = {b_if.npc_stall, b_if.IF_stall, b_if.ID_clr, b_if.IF_flush,
                  b_if.FowardAE, b_if.FowardBE, b_if.FowardAD, b_if.FowardBD,
                  b_if.md_busy, b_if.stall_cnt};
            n_cmp = n_cmp + 2;
            if (ga !== ea) begin
                n_bad = n_bad + 1;
                $display("FAIL fwd1_outputs t=%0t got=%h exp=%h", $time, ga, ea);
            end
            if (gb !== eb) begin
                n_bad = n_bad + 1;
                $display("FAIL fwd0_outputs t=%0t got=%h exp=%h", $time, gb, eb);
            end
        end
    end

    // Stimulus: directed scenarios, then random traffic, then the report.
    initial begin
        stim_t s, z;
        int guard;
        z = '0;
        cur = z; cur.rst = 1'b1;
        prev = cur;
        s = z; s.rst = 1'b1;
        step(s); step(s);
        // Load-use stall, then the same with write address 0.
        s = z; s.ex_m2r = 1'b1; s.ex_wa = 5'd5; s.id_rt = 5'd5;
        repeat (3) step(s);
        s.ex_wa = 5'd0;
        repeat (2) step(s);
        // Forwarding priority.
        s = z; s.mem_wa = 5'd7; s.wb_wa = 5'd7; s.ex_rs = 5'd7; s.mem_rw = 1'b1; s.wb_rw = 1'b1;
        step(s);
        s.ex_wa = 5'd7; s.ex_rw = 1'b1; s.id_rs = 5'd7;
        step(s);
        // Mul/div occupancy with a consumer waiting in ID.
        s = z; s.id_md_use = 1'b1; s.ex_md_start = 1'b1;
        step(s);
        s.ex_md_start = 1'b0;
        repeat (6) step(s);
        // Branch operand hazard and a stalled taken branch.
        s = z; s.id_branch = 1'b1; s.ex_rw = 1'b1; s.ex_wa = 5'd3; s.id_rs = 5'd3;
        step(s);
        s.branch_taken = 1'b1;
        step(s);
        // Reset while busy.
        s = z; s.id_md_use = 1'b1; s.ex_md_start = 1'b1;
        step(s);
        s.ex_md_start = 1'b0;
        step(s);
        s.rst = 1'b1;
        step(s);
        s.rst = 1'b0;
        repeat (3) step(s);
        // Long stall drives the 4-bit counter to saturation.
        s = z; s.mem_m2r = 1'b1; s.mem_wa = 5'd9; s.id_rs = 5'd9;
        repeat (20) step(s);
        // Random traffic.
        repeat (1500) step(rnd());
        s = z;
        step(s);
        guard = 0;
        while ((exp_a_q.size() > 0 || exp_b_q.size() > 0) && guard < 10) begin
            @(posedge clk);
            guard = guard + 1;
        end
        if (exp_a_q.size() > 0 || exp_b_q.size() > 0) begin
            n_bad = n_bad + 1;
            $display("FAIL drain pending=%0d required=0", exp_a_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
